// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : packet-level round-robin share of one Tx FIFO write port
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 8,
  parameter int MAX_PKT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       fifo_data,
  output logic                    fifo_wr,
  input  logic                    fifo_full,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int                 c_IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [0:0]         c_S_IDLE    = 1'b0;
  localparam logic [0:0]         c_S_XFER    = 1'b1;
  localparam logic [7:0]         c_CNT_MAX   = 8'(MAX_PKT - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_INIT = c_IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   c_ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [N_REQ-1:0]   r_grant;
  logic [c_IDX_W-1:0] r_gidx;
  logic [c_IDX_W-1:0] r_last_g;
  logic [7:0]         r_cnt;

  logic [c_IDX_W-1:0] w_win;
  logic               w_found;
  logic               w_any;
  logic               w_own_req;
  logic               w_own_last;
  logic [DATA_W-1:0]  w_own_data;
  logic               w_wr;
  logic               w_release;

  // Select the current owner's request, last flag and byte
  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gidx == c_IDX_W'(i)) begin
        w_own_req  = req[i];
        w_own_last = last[i];
        w_own_data = din[i*DATA_W +: DATA_W];
      end
    end
  end

  // First requester after the previous owner, wrapping; previous owner is tried last
  always_comb begin
    w_any   = |req;
    w_found = 1'b0;
    w_win   = r_last_g;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req[(int'(r_last_g) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = c_IDX_W'((int'(r_last_g) + k) % N_REQ);
      end
    end
  end

  assign w_wr      = (r_state == c_S_XFER) & w_own_req & ~fifo_full & ~reset;
  assign w_release = (r_state == c_S_XFER) &
                     (~w_own_req | (w_wr & (w_own_last | (r_cnt == c_CNT_MAX))));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: if (w_any)     w_next_state = c_S_XFER;
      c_S_XFER: if (w_release) w_next_state = c_S_IDLE;
      default:                 w_next_state = c_S_IDLE;
    endcase
  end

  // Grant, round-robin pointer and per-grant byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant  <= '0;
      r_gidx   <= '0;
      r_last_g <= c_LAST_INIT;
      r_cnt    <= 8'd0;
    end else if (r_state == c_S_IDLE) begin
      if (w_any) begin
        r_grant <= c_ONE << w_win;
        r_gidx  <= w_win;
        r_cnt   <= 8'd0;
      end
    end else if (w_release) begin
      r_grant  <= '0;
      r_last_g <= r_gidx;
      r_cnt    <= 8'd0;
    end else if (w_wr) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Outputs
  always_comb begin
    busy      = (r_state == c_S_XFER);
    grant     = r_grant;
    fifo_wr   = w_wr;
    ack       = w_wr ? r_grant : '0;
    fifo_data = (r_state == c_S_XFER) ? w_own_data : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed cycle-by-cycle bench, two requesters, MAX_PKT=4
// Revision 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] din;
  logic [1:0]  last;
  logic [1:0]  ack;
  logic [7:0]  fifo_data;
  logic        fifo_wr;
  logic        fifo_full;
  logic [1:0]  grant;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(2), .DATA_W(8), .MAX_PKT(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .last      (last),
    .ack       (ack),
    .fifo_data (fifo_data),
    .fifo_wr   (fifo_wr),
    .fifo_full (fifo_full),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs settle before the next rising edge
  task automatic drive(input logic rst, input logic [1:0] rq, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] lst, input logic full);
    @(negedge clk);
    reset     = rst;
    req       = rq;
    din       = {d1, d0};
    last      = lst;
    fifo_full = full;
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [1:0] g, input logic b,
                          input logic w, input logic [1:0] a, input logic [7:0] d);
    chk({tag, ".grant"}, 32'(grant),     32'(g));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".wr"},    32'(fifo_wr),   32'(w));
    chk({tag, ".ack"},   32'(ack),       32'(a));
    chk({tag, ".data"},  32'(fifo_data), 32'(d));
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; din = 16'h0; last = 2'b00; fifo_full = 1'b0;

    // Reset state
    drive(1, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    drive(1, 2'b01, 8'h41, 8'h00, 2'b00, 0);
    expect_o("rst", 2'b00, 0, 0, 2'b00, 8'h00);

    // Single packet 41 42 43
    drive(0, 2'b01, 8'h41, 8'h00, 2'b00, 0); expect_o("sp.arb", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b01, 8'h41, 8'h00, 2'b00, 0); expect_o("sp.b0",  2'b01, 1, 1, 2'b01, 8'h41);
    drive(0, 2'b01, 8'h42, 8'h00, 2'b00, 0); expect_o("sp.b1",  2'b01, 1, 1, 2'b01, 8'h42);
    drive(0, 2'b01, 8'h43, 8'h00, 2'b01, 0); expect_o("sp.b2",  2'b01, 1, 1, 2'b01, 8'h43);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 0); expect_o("sp.end", 2'b00, 0, 0, 2'b00, 8'h00);

    // Contention from reset: req0, idle, req1, idle, req0, idle, req1
    drive(1, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    drive(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 0); expect_o("ct.arb0", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b11, 8'hA0, 8'hB0, 2'b00, 0); expect_o("ct.a0",   2'b01, 1, 1, 2'b01, 8'hA0);
    drive(0, 2'b11, 8'hA1, 8'hB0, 2'b01, 0); expect_o("ct.a1",   2'b01, 1, 1, 2'b01, 8'hA1);
    drive(0, 2'b11, 8'hA2, 8'hB0, 2'b00, 0); expect_o("ct.arb1", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b11, 8'hA2, 8'hB0, 2'b00, 0); expect_o("ct.b0",   2'b10, 1, 1, 2'b10, 8'hB0);
    drive(0, 2'b11, 8'hA2, 8'hB1, 2'b10, 0); expect_o("ct.b1",   2'b10, 1, 1, 2'b10, 8'hB1);
    drive(0, 2'b11, 8'hA2, 8'hB2, 2'b00, 0); expect_o("ct.arb2", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b11, 8'hA2, 8'hB2, 2'b00, 0); expect_o("ct.a2",   2'b01, 1, 1, 2'b01, 8'hA2);
    drive(0, 2'b11, 8'hA3, 8'hB2, 2'b01, 0); expect_o("ct.a3",   2'b01, 1, 1, 2'b01, 8'hA3);
    drive(0, 2'b10, 8'h00, 8'hB2, 2'b00, 0); expect_o("ct.arb3", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b10, 8'h00, 8'hB2, 2'b10, 0); expect_o("ct.b2",   2'b10, 1, 1, 2'b10, 8'hB2);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 0); expect_o("ct.end",  2'b00, 0, 0, 2'b00, 8'h00);

    // Backpressure: full for 4 cycles after the first byte
    drive(0, 2'b01, 8'hC0, 8'h00, 2'b00, 0); expect_o("bp.arb", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b01, 8'hC0, 8'h00, 2'b00, 0); expect_o("bp.c0",  2'b01, 1, 1, 2'b01, 8'hC0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b01, 8'hC1, 8'h00, 2'b00, 1);
      expect_o($sformatf("bp.full%0d", i), 2'b01, 1, 0, 2'b00, 8'hC1);
    end
    drive(0, 2'b01, 8'hC1, 8'h00, 2'b00, 0); expect_o("bp.c1",  2'b01, 1, 1, 2'b01, 8'hC1);
    drive(0, 2'b01, 8'hC2, 8'h00, 2'b01, 0); expect_o("bp.c2",  2'b01, 1, 1, 2'b01, 8'hC2);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 0); expect_o("bp.end", 2'b00, 0, 0, 2'b00, 8'h00);

    // Forced release at 4 bytes; req1 then served; req0 resumes with its 5th byte
    drive(1, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    drive(0, 2'b11, 8'h10, 8'hE0, 2'b10, 0); expect_o("fr.arb0", 2'b00, 0, 0, 2'b00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      drive(0, 2'b11, 8'(8'h10 + k), 8'hE0, 2'b10, 0);
      expect_o($sformatf("fr.a%0d", k), 2'b01, 1, 1, 2'b01, 8'(8'h10 + k));
    end
    drive(0, 2'b11, 8'h14, 8'hE0, 2'b10, 0); expect_o("fr.arb1", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b11, 8'h14, 8'hE0, 2'b10, 0); expect_o("fr.e0",   2'b10, 1, 1, 2'b10, 8'hE0);
    drive(0, 2'b01, 8'h14, 8'h00, 2'b00, 0); expect_o("fr.arb2", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b01, 8'h14, 8'h00, 2'b00, 0); expect_o("fr.a4",   2'b01, 1, 1, 2'b01, 8'h14);
    drive(0, 2'b00, 8'h15, 8'h00, 2'b00, 0); expect_o("fr.drop", 2'b01, 1, 0, 2'b00, 8'h15);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 0); expect_o("fr.end",  2'b00, 0, 0, 2'b00, 8'h00);

    // Reset mid-packet while req1 owns; afterwards requester 0 has priority again
    drive(0, 2'b10, 8'h00, 8'h51, 2'b00, 0); expect_o("mr.arb", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b10, 8'h00, 8'h51, 2'b00, 0); expect_o("mr.b0",  2'b10, 1, 1, 2'b10, 8'h51);
    drive(1, 2'b10, 8'h00, 8'h52, 2'b00, 0);
    chk("mr.rst.wr",  32'(fifo_wr), 32'(0));
    chk("mr.rst.ack", 32'(ack),     32'(0));
    drive(0, 2'b11, 8'h61, 8'h52, 2'b01, 0); expect_o("mr.idle", 2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b11, 8'h61, 8'h52, 2'b01, 0); expect_o("mr.a0",   2'b01, 1, 1, 2'b01, 8'h61);

    // Abandon: req1 drops after one byte
    drive(0, 2'b10, 8'h00, 8'h71, 2'b00, 0); expect_o("ab.arb",  2'b00, 0, 0, 2'b00, 8'h00);
    drive(0, 2'b10, 8'h00, 8'h71, 2'b00, 0); expect_o("ab.b0",   2'b10, 1, 1, 2'b10, 8'h71);
    drive(0, 2'b00, 8'h00, 8'h72, 2'b00, 0); expect_o("ab.drop", 2'b10, 1, 0, 2'b00, 8'h72);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 0); expect_o("ab.end",  2'b00, 0, 0, 2'b00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single Tx FIFO write port among N_REQ byte-stream requesters, e.g. the Rx loopback path, a status reporter and a debug dumper. A grant is held for a whole packet, delimited by a per-requester last flag. A MAX_PKT byte cap forces release so one requester cannot starve the others. The block sits between the requesters and the Tx FIFO's bus_in/wr/full signals.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width fed to the Tx FIFO
MAX_PKT, 16, maximum bytes written per grant before forced release (2..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester valid; requester i has a byte ready on din slice i
din  input  N_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W]
last  input  N_REQ  the presented byte is the final byte of the packet
ack  output  N_REQ  one-hot pulse; requester i's byte was written this cycle
fifo_data  output  DATA_W  byte to the Tx FIFO bus_in
fifo_wr  output  1  write strobe to the Tx FIFO wr
fifo_full  input  1  Tx FIFO full flag
grant  output  N_REQ  one-hot current owner; all zero when idle
busy  output  1  a grant is held (state XFER)

Behaviour:
- Reset values:
  - state = IDLE; grant = 0; busy = 0; ack = 0; fifo_wr = 0; fifo_data = 0.
  - Byte counter cnt = 0; round-robin pointer last_g = N_REQ-1, so requester 0 has first priority.
- States are IDLE and XFER.
- IDLE:
  - If any req bit is high, pick the first requester with req=1 searching from (last_g+1) mod N_REQ upward, with wrap.
  - On the next edge: grant = one-hot(winner), cnt = 0, state = XFER.
  - No write occurs in IDLE, so there is 1 cycle of arbitration latency.
  - If no req bit is high, stay in IDLE.
- XFER, with owner g:
  - fifo_wr = req[g] & ~fifo_full. This is combinational from the registered grant and the current inputs.
  - fifo_data = din slice g while in XFER, otherwise 0.
  - ack[g] = fifo_wr; all other ack bits are 0.
  - When fifo_wr = 1: cnt <= cnt+1.
  - Release happens on the edge after a write where last[g] = 1 or cnt == MAX_PKT-1.
  - Release also happens on any edge where req[g] = 0, i.e. the requester abandoned the packet.
  - On release: state = IDLE, grant = 0, last_g = g, cnt = 0.
  - While fifo_full = 1 and req[g] = 1: hold the grant, no write, cnt unchanged. There is no timeout.
- Throughput:
  - One byte per cycle while the owner keeps req high and the FIFO is not full.
  - There is at least one idle cycle between consecutive grants.
- Fairness:
  - After owner g releases, requesters g+1 ... g-1 (wrapping) have priority over g.
  - Requester g is re-granted only if no other requester is requesting.
- Requests from non-owners are ignored during XFER. Their ack stays 0, and they must keep req and data stable until acked.
- cnt is 8 bits. The MAX_PKT check uses equality, and cnt never exceeds MAX_PKT-1.
- A reset asserted mid-packet forces IDLE on the next edge:
  - fifo_wr and ack are low in the reset cycle.
  - The partially sent packet is not resumed.
- The block never writes when fifo_full = 1, including in the cycle fifo_full rises.
- fifo_wr is never asserted outside XFER.
- grant, ack and fifo_wr are never multi-hot.

Test Plan:
- Single packet: reset, then req[0] presents 0x41,0x42,0x43 with last on 0x43 -> grant[0] one cycle after req, three consecutive fifo_wr with matching fifo_data and ack[0] pulses, busy drops after 0x43, grant = 0.
- Contention: req[0] and req[1] both high from reset, each with a 2-byte packet -> order is req0 packet, one idle cycle, req1 packet. Then req0 re-requesting while req1 requests again -> req1 is still served only after req0's next packet, i.e. strict alternation.
- Backpressure: fifo_full high for 4 cycles in the middle of a 3-byte packet -> no fifo_wr or ack during full, grant held, remaining bytes written after full drops, no byte lost or duplicated.
- Forced release: MAX_PKT=4, req[0] streams 10 bytes with no last while req[1] waits -> req0 sends 4 bytes, then req1 is granted, then req0 resumes with byte 5.
- Abandon and reset: req[1] granted then deasserted after 1 byte -> return to IDLE next edge. Separately, reset asserted during byte 2 -> fifo_wr = 0, state IDLE, next grant goes to requester 0.
